// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port and the data (load/store) port. Data wins contention unless
// fetch has lost STARVE_LIMIT contested grants in a row. Every output is
// driven straight from a register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access in flight, sampling requests
// ISSUE   | mem_en strobe asserted for the latched access
// WAIT    | counting down the memory read latency
// RESP    | one-cycle ack to the winning requester
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                last_grant
);

    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]          state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [STARVE_W-1:0] starve_q,     starve_d;
    logic                we_q,         we_d;
    logic                mem_en_q,     mem_en_d;
    logic                mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [DATA_W/8-1:0] mem_be_q,     mem_be_d;
    logic                if_ack_q,     if_ack_d;
    logic                d_ack_q,      d_ack_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,    d_rdata_d;
    logic                busy_q,       busy_d;
    logic                last_grant_q, last_grant_d;
    logic                fetch_wins;

    // Fetch wins when it is alone, or when data has starved it long enough.
    assign fetch_wins = if_req && (!d_req || (starve_q == STARVE_W'(STARVE_LIMIT)));

    // Next-state logic for the arbitration FSM and all registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        we_d         = we_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        busy_d       = busy_q;
        last_grant_d = last_grant_q;

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    if (fetch_wins) begin
                        we_d         = 1'b0;
                        mem_addr_d   = if_addr;
                        mem_wdata_d  = '0;
                        mem_be_d     = '0;
                        starve_d     = '0;
                        last_grant_d = 1'b0;
                    end else begin
                        we_d         = d_we;
                        mem_addr_d   = d_addr;
                        mem_wdata_d  = d_wdata;
                        mem_be_d     = d_be;
                        last_grant_d = 1'b1;
                        if (if_req && (starve_q != STARVE_W'(STARVE_LIMIT)))
                            starve_d = starve_q + STARVE_W'(1);
                    end
                    mem_en_d = 1'b1;
                    mem_we_d = fetch_wins ? 1'b0 : d_we;
                    busy_d   = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    // last_grant_q doubles as the identity of the current winner.
                    if (last_grant_q) begin
                        d_ack_d = 1'b1;
                        if (!we_q)
                            d_rdata_d = mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset abandons any access.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            starve_q     <= '0;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            we_q         <= we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign if_ack     = if_ack_q;
    assign if_rdata   = if_rdata_q;
    assign d_ack      = d_ack_q;
    assign d_rdata    = d_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default-latency instance and a
// MEM_LATENCY=1 instance, each with a small memory model whose read data
// depends on the address and is only valid in the correct cycle.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    // Default-latency instance signals
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        if_ack, d_ack, mem_en, mem_we, busy, last_grant;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    // MEM_LATENCY=1 instance signals
    logic        d_req1 = 1'b0;
    logic [31:0] d_addr1 = '0;
    logic        if_ack1, d_ack1, mem_en1, mem_we1, busy1, last_grant1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [3:0]  mem_be1;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy), .last_grant(last_grant)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .if_req(1'b0), .if_addr(32'h0), .if_ack(if_ack1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(1'b0), .d_addr(d_addr1), .d_wdata(32'h0), .d_be(4'h0),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_be(mem_be1), .mem_rdata(mem_rdata1), .busy(busy1), .last_grant(last_grant1)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h8) ? 32'h55 : a + 32'h3;
    endfunction

    // Latency-2 memory: data valid two cycles after the mem_en cycle.
    logic        pv0 = 1'b0, pv1 = 1'b0;
    logic [31:0] pa0 = '0, pa1 = '0;
    always @(posedge clock) begin
        pv0 <= mem_en;
        pa0 <= mem_addr;
        pv1 <= pv0;
        pa1 <= pa0;
    end
    assign mem_rdata = pv1 ? mem_val(pa1) : 32'hBAD0BAD0;

    // Latency-1 memory: data valid the cycle after the mem_en cycle.
    logic        qv = 1'b0;
    logic [31:0] qa = '0;
    always @(posedge clock) begin
        qv <= mem_en1;
        qa <= mem_addr1;
    end
    assign mem_rdata1 = qv ? mem_val(qa) : 32'hBAD1BAD1;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    bit exp_d [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int nack;
        logic both;
        logic any_ack;

        // Reset state
        step(); step();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_last_grant", 32'(last_grant), 32'd0);
        reset = 1'b1;
        step();

        // Fetch-only read
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chk("f_mem_en_c1", 32'(mem_en), 32'd1);
        chk("f_mem_we_c1", 32'(mem_we), 32'd0);
        chk("f_mem_addr_c1", mem_addr, 32'h10);
        chk("f_busy_c1", 32'(busy), 32'd1);
        step();
        chk("f_mem_en_c2", 32'(mem_en), 32'd0);
        step();
        chk("f_ack_c3", 32'(if_ack), 32'd0);
        step();
        chk("f_ack_c4", 32'(if_ack), 32'd1);
        chk("f_rdata_c4", if_rdata, 32'h13);
        chk("f_dack_c4", 32'(d_ack), 32'd0);
        chk("f_busy_c4", 32'(busy), 32'd1);
        chk("f_grant", 32'(last_grant), 32'd0);
        if_req = 1'b0;
        step();
        chk("f_ack_c5", 32'(if_ack), 32'd0);
        chk("f_busy_c5", 32'(busy), 32'd0);
        chk("f_rdata_hold", if_rdata, 32'h13);

        // Data store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
        step();
        chk("s_mem_en_c1", 32'(mem_en), 32'd1);
        chk("s_mem_we_c1", 32'(mem_we), 32'd1);
        chk("s_mem_addr_c1", mem_addr, 32'h40);
        chk("s_mem_wdata_c1", mem_wdata, 32'hDEADBEEF);
        chk("s_mem_be_c1", 32'(mem_be), 32'hF);
        chk("s_grant", 32'(last_grant), 32'd1);
        step();
        chk("s_mem_we_c2", 32'(mem_we), 32'd0);
        chk("s_mem_addr_c2", mem_addr, 32'h40);
        step(); step();
        chk("s_dack_c4", 32'(d_ack), 32'd1);
        chk("s_iack_c4", 32'(if_ack), 32'd0);
        chk("s_drdata_c4", d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        step();
        chk("s_dack_c5", 32'(d_ack), 32'd0);

        // Load with inputs changed after grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        step();
        chk("p_mem_en_c1", 32'(mem_en), 32'd1);
        step();
        d_addr = 32'h80; d_req = 1'b0;
        step();
        chk("p_mem_addr_c3", mem_addr, 32'h40);
        chk("p_dack_c3", 32'(d_ack), 32'd0);
        step();
        chk("p_dack_c4", 32'(d_ack), 32'd1);
        chk("p_drdata_c4", d_rdata, 32'h43);
        step();
        chk("p_busy_c5", 32'(busy), 32'd0);

        // Continuous contention
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        nack = 0; both = 1'b0;
        for (int c = 0; c < 80 && nack < 8; c++) begin
            step();
            if (if_ack && d_ack) both = 1'b1;
            if (if_ack || d_ack) begin
                chk($sformatf("cont_order_%0d", nack), 32'(d_ack), 32'(exp_d[nack]));
                if (d_ack) chk("cont_drdata", d_rdata, 32'h203);
                else       chk("cont_irdata", if_rdata, 32'h103);
                nack++;
                if (nack == 8) begin
                    if_req = 1'b0; d_req = 1'b0;
                end
            end
        end
        chk("cont_count", 32'(nack), 32'd8);
        chk("cont_excl", 32'(both), 32'd0);
        step();

        // Reset in the middle of a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        step(); step();
        reset = 1'b0;
        step();
        d_req = 1'b0;
        chk("r_mem_en", 32'(mem_en), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_mem_addr", mem_addr, 32'd0);
        chk("r_drdata", d_rdata, 32'd0);
        chk("r_irdata", if_rdata, 32'd0);
        chk("r_last_grant", 32'(last_grant), 32'd1 - 32'd1);
        reset = 1'b1;
        any_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (if_ack || d_ack) any_ack = 1'b1;
        end
        chk("r_no_ack", 32'(any_ack), 32'd0);
        if_req = 1'b1; if_addr = 32'h20;
        step(); step(); step();
        chk("r_fetch_ack_c3", 32'(if_ack), 32'd0);
        step();
        chk("r_fetch_ack_c4", 32'(if_ack), 32'd1);
        chk("r_fetch_rdata", if_rdata, 32'h23);
        if_req = 1'b0;
        step();

        // MEM_LATENCY=1 instance: single load
        d_req1 = 1'b1; d_addr1 = 32'h8;
        step();
        chk("l1_mem_en_c1", 32'(mem_en1), 32'd1);
        step();
        chk("l1_dack_c2", 32'(d_ack1), 32'd0);
        step();
        chk("l1_dack_c3", 32'(d_ack1), 32'd1);
        chk("l1_drdata_c3", d_rdata1, 32'h55);
        d_req1 = 1'b0;
        step();
        chk("l1_dack_c4", 32'(d_ack1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single-ported main memory between the pipeline's instruction-fetch port and its data (load/store) port. Each granted access is issued to the memory, waited out over the memory's fixed read latency, and acknowledged back to the winning requester. Data accesses have priority. A starvation counter guarantees fetch progress. The block sits in top between the IF/MEM pipeline stages and main_memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
MEM_LATENCY, 2, cycles from the mem_en cycle to the mem_rdata-valid cycle (>=1)
STARVE_LIMIT, 3, consecutive contested data wins before fetch is forced (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse, fetch complete
if_rdata  out  DATA_W  fetch data, valid in ack cycle, held until next if_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_ack  out  1  one-cycle pulse, data access complete
d_rdata  out  DATA_W  load data, held until next load ack
mem_en  out  1  one-cycle memory access strobe
mem_we  out  1  write strobe, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data
busy  out  1  high when state != IDLE
last_grant  out  1  0 = fetch, 1 = data; updated at each grant

Behaviour:
- Reset (reset==0 at an edge): state IDLE. All outputs 0. starve_cnt = 0. Any in-flight access is abandoned without an ack. This applies mid-operation too.
- All outputs are registered.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: at the edge where any req is high, pick the winner, latch its addr/we/wdata/be, and go to ISSUE. With no req, stay in IDLE.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high and starve_cnt == STARVE_LIMIT: fetch wins.
  - Both high otherwise: data wins.
- starve_cnt update:
  - Increments (saturating at STARVE_LIMIT) when data wins while if_req is high.
  - Clears to 0 when fetch wins.
  - Unchanged when data wins uncontested.
- ISSUE (one cycle): mem_en=1, mem_we = latched we (0 for fetch), mem_addr/wdata/be = latched values. Counter loads MEM_LATENCY; go to WAIT.
- WAIT: mem_en=0, mem_we=0; mem_addr/wdata/be hold. Counter decrements each cycle. At the edge where mem_rdata is valid (MEM_LATENCY cycles after the ISSUE cycle), capture mem_rdata and go to RESP.
- RESP (one cycle): the winner's ack=1.
  - Fetch win: if_rdata = captured data.
  - Data load: d_rdata = captured data.
  - Data store: d_rdata unchanged.
  - Then go to IDLE.
- Timing: req high in cycle 0 while IDLE -> mem_en in cycle 1 -> ack in cycle 2+MEM_LATENCY (cycle 4 at default).
- Requester obligations:
  - Deassert req, or present the next request, by the edge ending the ack cycle.
  - IDLE samples req at the following edge. There is no back-to-back pipelining; the minimum access period is MEM_LATENCY+3 cycles.
- Requests are latched at grant. Input changes after grant (including req dropped early) are ignored; the access completes and acks normally.
- Acks are mutually exclusive. Exactly one ack per grant. Never an ack without a grant.
- mem_we never asserts without mem_en. Fetch never writes.

Test Plan:
- Fetch-only read: if_req=1, if_addr=0x10, memory returns 0x00000013 -> mem_en=1 and mem_addr=0x10 in cycle 1, mem_we=0; if_ack=1 in cycle 4 with if_rdata=0x00000013; d_ack stays 0; busy high cycles 1-4.
- Data store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0xF -> mem_en=mem_we=1 in cycle 1 with those values; d_ack in cycle 4; d_rdata unchanged; last_grant=1.
- Continuous contention: if_req and d_req held high, each re-asserted after its ack -> grant order D,D,D,IF,D,D,D,IF; no ack ever lost.
- Reset mid-access: reset=0 for one edge during WAIT -> next cycle all outputs 0, busy=0, no ack for the abandoned access; after release, a fetch of 0x20 completes with if_ack 4 cycles later.
- Post-grant input change: d_addr changed from 0x40 to 0x80 and d_req dropped during WAIT -> mem_addr stays 0x40 and d_ack still pulses in cycle 4.
- MEM_LATENCY=1 build: a single load of 0x8 returning 0x55 -> d_ack in cycle 3 with d_rdata=0x00000055.
